// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target state encoding and ACK/NACK bit levels.
// Used by both the expander responder and the existing I2C initiator.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// SCL/SDA synchroniser, stability filter and edge/START/STOP detector.
// Events are registered one-cycle pulses; sda is the filtered level aligned with them.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    localparam int CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic [CNT_W-1:0]       scl_cnt;
    logic [CNT_W-1:0]       sda_cnt;
    logic                   scl_f;
    logic                   sda_f;
    logic                   scl_d;
    logic                   sda_d;

    // Lines reset to the idle-high bus level so leaving reset never looks like START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};

            if (scl_sync[SYNC_STAGES-1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CNT_LAST) begin
                scl_f   <= scl_sync[SYNC_STAGES-1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end

            if (sda_sync[SYNC_STAGES-1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CNT_LAST) begin
                sda_f   <= sda_sync[SYNC_STAGES-1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end

            scl_d    <= scl_f;
            sda_d    <= sda_f;
            scl_rise <= scl_f & ~scl_d;
            scl_fall <= ~scl_f & scl_d;
            // SCL must be high on both sides of the SDA edge to count as START/STOP.
            start    <= scl_f & scl_d & sda_d & ~sda_f;
            stop     <= scl_f & scl_d & ~sda_d & sda_f;
        end
    end

    assign sda = sda_d;

endmodule

// File: rtl/i2c_expander_responder.sv
// PCF8574-style I2C target: 8-bit write port and 8-bit read port behind one address.
// Filtering lives in i2c_line_filter; the protocol FSM is here.
module i2c_expander_responder #(
    parameter logic [6:0] ADDR        = 7'h27,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] port_out,
    input  logic [7:0] port_in,
    output logic       wr_strobe,
    output logic       rd_strobe,
    output logic       busy
);

    import i2c_pkg::*;

    logic           scl_rise;
    logic           scl_fall;
    logic           start;
    logic           stop;
    logic           sda;
    i2c_tgt_state_t state;
    logic [2:0]     bit_cnt;
    logic           byte_done;
    logic           rw;
    logic           ack_bit;
    logic [7:0]     shreg;
    logic [7:0]     tx;

    i2c_line_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER     (FILTER)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop),
        .sda     (sda)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            ack_bit   <= I2C_NACK;
            sda_oe    <= 1'b0;
            port_out  <= 8'hFF;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start) begin
                state     <= i2c_pkg::ADDR;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    i2c_pkg::ADDR, WRITE: begin
                        if (scl_rise) begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            byte_done <= (bit_cnt == 3'd7);
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (state == WRITE) begin
                                sda_oe    <= 1'b1;
                                port_out  <= shreg;
                                wr_strobe <= 1'b1;
                                state     <= WRITE_ACK;
                            end else if (shreg[7:1] == ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shreg[0];
                                state  <= ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (rw) begin
                                rd_strobe <= 1'b1;
                                sda_oe    <= ~port_in[7];
                                state     <= READ;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WRITE;
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WRITE;
                        end
                    end
                    READ: begin
                        // bit_cnt counts bits already clocked out; 7 means bit 0 just went.
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                state  <= READ_ACK;
                            end else begin
                                sda_oe <= ~tx[6];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            ack_bit <= sda;
                        end else if (scl_fall) begin
                            if (ack_bit == I2C_ACK) begin
                                bit_cnt   <= 3'd0;
                                rd_strobe <= 1'b1;
                                sda_oe    <= ~port_in[7];
                                state     <= READ;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    IGNORE: sda_oe <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Shift registers carry data only; their contents are meaningful once a byte is framed.
    always_ff @(posedge clk) begin
        if (scl_rise && (state == i2c_pkg::ADDR || state == WRITE)) begin
            shreg <= {shreg[6:0], sda};
        end
        if (scl_fall) begin
            if ((state == ADDR_ACK && rw) || (state == READ_ACK && ack_bit == I2C_ACK)) begin
                tx <= port_in;
            end else if (state == READ) begin
                tx <= {tx[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_i2c_expander_responder.sv
// Directed bench for the I2C expander target: a bit-banged initiator drives the bus,
// a vector table covers single-byte writes, hand sequences cover the multi-cycle cases.
module tb_i2c_expander_responder;

    localparam int Q = 25;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_port;
        int         exp_wr;
    } wvec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] port_out;
    logic [7:0] port_in;
    logic       wr_strobe;
    logic       rd_strobe;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit seen55 = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_expander_responder dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .port_out (port_out),
        .port_in  (port_in),
        .wr_strobe(wr_strobe),
        .rd_strobe(rd_strobe),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (rd_strobe) rd_cnt++;
        if (port_out == 8'h55) seen55 = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; hq();
        scl_m = 1'b1; hq();
        sda_m = 1'b0; hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hq();
        scl_m = 1'b1; hq();
        sda_m = 1'b1; hq();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    hq();
        scl_m = 1'b1; hq(); hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; hq();
        scl_m = 1'b1; hq();
        b = sda_bus;  hq();
        scl_m = 1'b0; hq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        acked = (a == 1'b0);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    initial begin
        wvec_t      vec [6];
        logic       ack;
        logic [7:0] rd;
        int         w0;
        int         r0;

        vec[0] = '{7'h26, 8'h12, 1'b0, 8'hFF, 0};
        vec[1] = '{7'h27, 8'hA5, 1'b1, 8'hA5, 1};
        vec[2] = '{7'h13, 8'h3C, 1'b0, 8'hA5, 0};
        vec[3] = '{7'h27, 8'h00, 1'b1, 8'h00, 1};
        vec[4] = '{7'h67, 8'hFF, 1'b0, 8'h00, 0};
        vec[5] = '{7'h27, 8'hFF, 1'b1, 8'hFF, 1};

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; port_in = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_sda_oe",   32'(sda_oe),    32'h0);
        check("reset_port_out", 32'(port_out),  32'hFF);
        check("reset_wr",       32'(wr_strobe), 32'h0);
        check("reset_rd",       32'(rd_strobe), 32'h0);
        check("reset_busy",     32'(busy),      32'h0);
        rst = 1'b0;
        hq();

        for (int v = 0; v < 6; v++) begin
            w0 = wr_cnt;
            i2c_start();
            write_byte({vec[v].addr, 1'b0}, ack);
            check($sformatf("vec%0d_addr_ack", v), 32'(ack), 32'(vec[v].exp_ack));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vec[v].exp_ack));
            write_byte(vec[v].data, ack);
            check($sformatf("vec%0d_data_ack", v), 32'(ack), 32'(vec[v].exp_ack));
            i2c_stop();
            hq();
            check($sformatf("vec%0d_port", v), 32'(port_out), 32'(vec[v].exp_port));
            check($sformatf("vec%0d_wr_cnt", v), 32'(wr_cnt - w0), 32'(vec[v].exp_wr));
            check($sformatf("vec%0d_busy_after_stop", v), 32'(busy), 32'h0);
        end

        // Three-byte write
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'h4E, ack);
        check("multi_addr_ack", 32'(ack), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            write_byte(8'(k), ack);
            check($sformatf("multi_data%0d_ack", k), 32'(ack), 32'h1);
        end
        i2c_stop();
        hq();
        check("multi_port", 32'(port_out), 32'h03);
        check("multi_wr_cnt", 32'(wr_cnt - w0), 32'd3);

        // Read two bytes, port_in changing between them, NACK on the second
        r0 = rd_cnt;
        port_in = 8'h3C;
        i2c_start();
        write_byte(8'h4F, ack);
        check("read_addr_ack", 32'(ack), 32'h1);
        read_byte(rd);
        check("read_byte0", 32'(rd), 32'h3C);
        port_in = 8'hC3;
        write_bit(1'b0);
        read_byte(rd);
        check("read_byte1", 32'(rd), 32'hC3);
        write_bit(1'b1);
        check("read_nack_release", 32'(sda_oe), 32'h0);
        check("read_rd_cnt", 32'(rd_cnt - r0), 32'd2);
        check("read_port_kept", 32'(port_out), 32'h03);
        i2c_stop();
        hq();

        // Repeated START after four data bits of 0x55
        w0 = wr_cnt;
        seen55 = 1'b0;
        i2c_start();
        write_byte(8'h4E, ack);
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        i2c_start();
        check("sr_port_unchanged", 32'(port_out), 32'h03);
        write_byte(8'h4E, ack);
        check("sr_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h0F, ack);
        check("sr_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        hq();
        check("sr_port", 32'(port_out), 32'h0F);
        check("sr_never_55", 32'(seen55), 32'h0);
        check("sr_wr_cnt", 32'(wr_cnt - w0), 32'd1);

        // Reset while the data ACK is being driven
        i2c_start();
        write_byte(8'h4E, ack);
        for (int i = 7; i >= 0; i--) write_bit(((8'h77 >> i) & 8'h01) != 0);
        check("rst_ack_driven", 32'(sda_oe), 32'h1);
        check("rst_port_loaded", 32'(port_out), 32'h77);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_sda_release", 32'(sda_oe), 32'h0);
        check("rst_port_reset", 32'(port_out), 32'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sda_m = 1'b1; hq();
        scl_m = 1'b1; hq();
        check("rst_ack_slot_high", 32'(sda_bus), 32'h1);
        hq();
        scl_m = 1'b0; hq();
        i2c_stop();
        hq();
        check("rst_busy", 32'(busy), 32'h0);
        i2c_start();
        write_byte(8'h4E, ack);
        check("post_rst_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h5A, ack);
        check("post_rst_data_ack", 32'(ack), 32'h1);
        i2c_stop();
        hq();
        check("post_rst_port", 32'(port_out), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
